// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: PORT_OUT register, synchronized PORT_IN, rising-edge capture and IRQ.
// Optional compare timer (TMR_COUNT/TMR_CMP/TMR_CTRL) is built only when MMIO_TIMER_EN is defined.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0040,
  parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Selected,
  output logic [31:0] PortOut,
  output logic        Irq
);

  localparam logic [3:0] OFF_PORT_OUT = 4'h0;
  localparam logic [3:0] OFF_PORT_IN  = 4'h1;
  localparam logic [3:0] OFF_EDGE     = 4'h2;
  localparam logic [3:0] OFF_COUNT    = 4'h3;
  localparam logic [3:0] OFF_CMP      = 4'h4;
  localparam logic [3:0] OFF_CTRL     = 4'h5;

  logic [3:0]  offset;
  logic        wr_en;
  logic        unused_addr_lsb;
  logic [31:0] port_out_q, port_out_d;
  logic [7:0]  sync1_q, sync1_d;
  logic [7:0]  in_sync_q, in_sync_d;
  logic [7:0]  prev_q, prev_d;
  logic [7:0]  edge_stat_q, edge_stat_d;
  logic [7:0]  edge_w1c, rise;
  logic [31:0] tmr_count, tmr_cmp, tmr_ctrl;
  logic        tmr_flag;
  logic [31:0] rdata;

  // Full-word access only; byte-lane bits are deliberately ignored.
  assign unused_addr_lsb = ^Address[1:0];
  assign offset   = Address[5:2];
  assign Selected = (Address[31:6] == BASE_ADDR[31:6]);
  assign wr_en    = Selected && MemWrite;
  assign rise     = in_sync_q & ~prev_q;

  always_comb begin
    port_out_d = port_out_q;
    if (wr_en && (offset == OFF_PORT_OUT)) port_out_d = WriteData;
    sync1_d   = PortIn;
    in_sync_d = sync1_q;
    prev_d    = in_sync_q;
    edge_w1c  = (wr_en && (offset == OFF_EDGE)) ? WriteData[7:0] : 8'h00;
    // A new edge in the same cycle as its W1C is kept, so no event is lost.
    edge_stat_d = rise | (edge_stat_q & ~edge_w1c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q  <= OUT_RESET;
      sync1_q     <= 8'h00;
      in_sync_q   <= 8'h00;
      prev_q      <= 8'h00;
      edge_stat_q <= 8'h00;
    end else begin
      port_out_q  <= port_out_d;
      sync1_q     <= sync1_d;
      in_sync_q   <= in_sync_d;
      prev_q      <= prev_d;
      edge_stat_q <= edge_stat_d;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        flag_q, flag_d;
  logic        match;

  always_comb begin
    match   = en_q && (count_q == cmp_q);
    count_d = count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    ar_d    = ar_q;
    flag_d  = flag_q;
    if (en_q) begin
      if (match) begin
        if (ar_q) count_d = 32'h0;
        else      en_d    = 1'b0;
      end else begin
        count_d = count_q + 32'h1;
      end
    end
    if (wr_en && (offset == OFF_CMP)) cmp_d = WriteData;
    // Software EN/AUTORELOAD override the hardware one-shot stop; hardware FLAG set overrides W1C.
    if (wr_en && (offset == OFF_CTRL)) begin
      en_d = WriteData[0];
      ar_d = WriteData[1];
      if (WriteData[2]) flag_d = 1'b0;
    end
    if (match) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 32'h0;
      cmp_q   <= 32'h0;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      flag_q  <= flag_d;
    end
  end

  assign tmr_count = count_q;
  assign tmr_cmp   = cmp_q;
  assign tmr_ctrl  = {29'h0, flag_q, ar_q, en_q};
  assign tmr_flag  = flag_q;
`else
  assign tmr_count = 32'h0;
  assign tmr_cmp   = 32'h0;
  assign tmr_ctrl  = 32'h0;
  assign tmr_flag  = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0;
    case (offset)
      OFF_PORT_OUT: rdata = port_out_q;
      OFF_PORT_IN:  rdata = {24'h0, in_sync_q};
      OFF_EDGE:     rdata = {24'h0, edge_stat_q};
      OFF_COUNT:    rdata = tmr_count;
      OFF_CMP:      rdata = tmr_cmp;
      OFF_CTRL:     rdata = tmr_ctrl;
      default:      rdata = 32'h0;
    endcase
  end

  assign ReadData = (Selected && MemRead) ? rdata : 32'h0;
  assign PortOut  = port_out_q;
  assign Irq      = (|edge_stat_q) | tmr_flag;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder; timer scenarios follow MMIO_TIMER_EN.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [7:0]  PortIn = 8'h00;
  logic [31:0] ReadData;
  logic        Selected;
  logic [31:0] PortOut;
  logic        Irq;

  int n_checks = 0;
  int n_fail = 0;

  mmio_port_responder #(.BASE_ADDR(BASE), .OUT_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
    .ReadData(ReadData), .Selected(Selected), .PortOut(PortOut), .Irq(Irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    step(2);
    reset = 1'b1;
  endtask

  // driver tasks: called at a negedge; writes consume one rising edge, reads none
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address = addr; WriteData = data; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address = addr; MemRead = 1'b1;
    #1 data = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    if (PortOut !== 32'h0 || Irq !== 1'b0) begin
      $display("FAIL reset_init: PortOut=%h Irq=%b want 0/0", PortOut, Irq); n_fail++;
    end
    n_checks++;
    bus_write(BASE, 32'hA5);
    PortIn = 8'h01;
    step(4);
    if (PortOut !== 32'hA5 || Irq !== 1'b1) begin
      $display("FAIL reset_pre: PortOut=%h Irq=%b want a5/1", PortOut, Irq); n_fail++;
    end
    n_checks++;
    #2 reset = 1'b0;
    #1;
    if (PortOut !== 32'h0 || Irq !== 1'b0) begin
      $display("FAIL reset_async: PortOut=%h Irq=%b want 0/0", PortOut, Irq); n_fail++;
    end
    n_checks++;
    Address = BASE; MemRead = 1'b1;
    #1;
    if (ReadData !== 32'h0) begin
      $display("FAIL reset_rdata: got %h want 0", ReadData); n_fail++;
    end
    n_checks++;
    MemRead = 1'b0; PortIn = 8'h00;
    step(1);
    reset = 1'b1;
    bus_read(BASE + 32'h04, r);
    if (r !== 32'h0) begin
      $display("FAIL reset_port_in: got %h want 0", r); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_port_out();
    logic [31:0] r;
    do_reset();
    bus_write(BASE, 32'h1234_5678);
    if (PortOut !== 32'h1234_5678) begin
      $display("FAIL port_out_pin: got %h want 12345678", PortOut); n_fail++;
    end
    n_checks++;
    bus_read(BASE + 32'h03, r);
    if (r !== 32'h1234_5678) begin
      $display("FAIL port_out_read: got %h want 12345678", r); n_fail++;
    end
    n_checks++;
    Address = BASE + 32'h40; MemRead = 1'b1;
    #1;
    if (Selected !== 1'b0 || ReadData !== 32'h0) begin
      $display("FAIL decode_outside: Selected=%b ReadData=%h want 0/0", Selected, ReadData); n_fail++;
    end
    n_checks++;
    Address = BASE + 32'h3C;
    #1;
    if (Selected !== 1'b1) begin
      $display("FAIL decode_inside: Selected=%b want 1", Selected); n_fail++;
    end
    n_checks++;
    MemRead = 1'b0;
    bus_write(BASE + 32'h40, 32'hDEAD_0000);
    if (PortOut !== 32'h1234_5678) begin
      $display("FAIL write_outside: PortOut=%h want 12345678", PortOut); n_fail++;
    end
    n_checks++;
    // simultaneous read and write returns the old value this cycle
    Address = BASE; WriteData = 32'hCAFE_BABE; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    if (ReadData !== 32'h1234_5678) begin
      $display("FAIL rw_same_cycle: got %h want 12345678", ReadData); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    if (PortOut !== 32'hCAFE_BABE) begin
      $display("FAIL rw_write: got %h want cafebabe", PortOut); n_fail++;
    end
    n_checks++;
    bus_write(BASE + 32'h18, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h18, r);
    if (r !== 32'h0) begin
      $display("FAIL reserved: got %h want 0", r); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_edge_capture();
    logic [31:0] r;
    do_reset();
    PortIn = 8'h81;
    step(1);
    bus_read(BASE + 32'h04, r);
    if (r !== 32'h0) begin
      $display("FAIL sync_latency1: got %h want 0", r); n_fail++;
    end
    n_checks++;
    step(1);
    bus_read(BASE + 32'h04, r);
    if (r !== 32'h81) begin
      $display("FAIL sync_latency2: got %h want 81", r); n_fail++;
    end
    n_checks++;
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h0 || Irq !== 1'b0) begin
      $display("FAIL edge_early: stat=%h Irq=%b want 0/0", r, Irq); n_fail++;
    end
    n_checks++;
    step(1);
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h81 || Irq !== 1'b1) begin
      $display("FAIL edge_set: stat=%h Irq=%b want 81/1", r, Irq); n_fail++;
    end
    n_checks++;
    bus_write(BASE + 32'h08, 32'h01);
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h80 || Irq !== 1'b1) begin
      $display("FAIL edge_w1c0: stat=%h Irq=%b want 80/1", r, Irq); n_fail++;
    end
    n_checks++;
    bus_write(BASE + 32'h08, 32'hFFFF_FF80);
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h0 || Irq !== 1'b0) begin
      $display("FAIL edge_w1c7: stat=%h Irq=%b want 0/0", r, Irq); n_fail++;
    end
    n_checks++;
    PortIn = 8'h00;
    step(4);
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h0) begin
      $display("FAIL edge_fall: stat=%h want 0", r); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_set_wins();
    logic [31:0] r;
    do_reset();
    PortIn = 8'h01;
    step(4);
    PortIn = 8'h00;
    step(4);
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h01) begin
      $display("FAIL setwin_pre: stat=%h want 1", r); n_fail++;
    end
    n_checks++;
    PortIn = 8'h01;
    step(2);
    bus_write(BASE + 32'h08, 32'h01);
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h01 || Irq !== 1'b1) begin
      $display("FAIL setwin: stat=%h Irq=%b want 1/1", r, Irq); n_fail++;
    end
    n_checks++;
    bus_write(BASE + 32'h08, 32'h01);
    bus_read(BASE + 32'h08, r);
    if (r !== 32'h0 || Irq !== 1'b0) begin
      $display("FAIL setwin_clear: stat=%h Irq=%b want 0/0", r, Irq); n_fail++;
    end
    n_checks++;
  endtask

`ifdef MMIO_TIMER_EN
  task automatic test_timer();
    logic [31:0] r;
    logic [31:0] exp_cnt [6];
    exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    // one-shot
    do_reset();
    bus_write(BASE + 32'h10, 32'd3);
    bus_write(BASE + 32'h14, 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'h0C, r);
      if (r !== exp_cnt[i]) begin
        $display("FAIL oneshot_count%0d: got %0d want %0d", i, r, exp_cnt[i]); n_fail++;
      end
      n_checks++;
      step(1);
    end
    bus_read(BASE + 32'h14, r);
    if (r !== 32'h4 || Irq !== 1'b1) begin
      $display("FAIL oneshot_ctrl: ctrl=%h Irq=%b want 4/1", r, Irq); n_fail++;
    end
    n_checks++;
    step(2);
    bus_read(BASE + 32'h0C, r);
    if (r !== 32'd3) begin
      $display("FAIL oneshot_hold: got %0d want 3", r); n_fail++;
    end
    n_checks++;
    bus_write(BASE + 32'h14, 32'h4);
    bus_read(BASE + 32'h14, r);
    if (r !== 32'h0 || Irq !== 1'b0) begin
      $display("FAIL flag_w1c: ctrl=%h Irq=%b want 0/0", r, Irq); n_fail++;
    end
    n_checks++;
    // autoreload
    do_reset();
    bus_write(BASE + 32'h10, 32'd3);
    bus_write(BASE + 32'h14, 32'h3);
    for (int i = 0; i < 6; i++) begin
      bus_read(BASE + 32'h0C, r);
      if (r !== exp_cnt[i]) begin
        $display("FAIL reload_count%0d: got %0d want %0d", i, r, exp_cnt[i]); n_fail++;
      end
      n_checks++;
      if (i == 4) begin
        bus_read(BASE + 32'h14, r);
        if (r !== 32'h7) begin
          $display("FAIL reload_ctrl: got %h want 7", r); n_fail++;
        end
        n_checks++;
      end
      step(1);
    end
    // compare value zero matches on the first enabled edge
    do_reset();
    bus_write(BASE + 32'h14, 32'h1);
    step(1);
    bus_read(BASE + 32'h14, r);
    if (r !== 32'h4 || Irq !== 1'b1) begin
      $display("FAIL cmp_zero: ctrl=%h Irq=%b want 4/1", r, Irq); n_fail++;
    end
    n_checks++;
  endtask
`else
  task automatic test_timer_absent();
    logic [31:0] r;
    do_reset();
    bus_write(BASE + 32'h10, 32'h3);
    bus_write(BASE + 32'h14, 32'h7);
    step(6);
    for (int i = 0; i < 3; i++) begin
      bus_read(BASE + 32'h0C + 32'(4 * i), r);
      if (r !== 32'h0) begin
        $display("FAIL no_timer_reg%0d: got %h want 0", i, r); n_fail++;
      end
      n_checks++;
    end
    if (Irq !== 1'b0) begin
      $display("FAIL no_timer_irq: Irq=%b want 0", Irq); n_fail++;
    end
    n_checks++;
    PortIn = 8'h10;
    step(3);
    if (Irq !== 1'b1) begin
      $display("FAIL no_timer_edge_irq: Irq=%b want 1", Irq); n_fail++;
    end
    n_checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_port_out();
    test_edge_capture();
    test_set_wins();
`ifdef MMIO_TIMER_EN
    test_timer();
`else
    test_timer_absent();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
